// File: rtl/uart_fifo_bridge_if.sv
// Host-side handshake bundle for the UART FIFO bridge: TX byte push and RX byte pop.
interface uart_fifo_bridge_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;

  modport master (output tx_valid, tx_data, rx_ready, input tx_ready, rx_valid, rx_data);
  modport slave  (input tx_valid, tx_data, rx_ready, output tx_ready, rx_valid, rx_data);
endinterface

// File: rtl/uart_fifo_bridge.sv
// UART FIFO bridge: host TX bytes queue in a FIFO and launch one frame at a time into the
// UART transmitter; bytes completed by the receiver queue in a FIFO for the host (FWFT).
module uart_fifo_bridge #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  uart_fifo_bridge_if.slave host,
  input  logic              tx_enable_i,
  input  logic              rx_enable_i,
  input  logic              flush_i,
  output logic [ADDR_W:0]   tx_count_o,
  output logic [ADDR_W:0]   rx_count_o,
  output logic              rx_overflow_o,
  output logic [7:0]        t_in_o,
  output logic              tx_en_o,
  input  logic              t_done_i,
  output logic              rx_en_o,
  input  logic [7:0]        r_data_i,
  input  logic              r_done_i
);
  localparam logic [ADDR_W:0]   FULL  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT1  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR1  = ADDR_W'(1);

  typedef enum logic {IDLE, BUSY} tx_state_e;

  tx_state_e         state_q, state_d;
  logic              launch;

  logic [7:0]        tx_mem [DEPTH];
  logic [ADDR_W-1:0] tx_wptr_q, tx_rptr_q;
  logic [ADDR_W:0]   tx_cnt_q, tx_cnt_d;
  logic              tx_push, tx_pop;
  logic [7:0]        t_in_q;
  logic              tx_en_q;

  logic [7:0]        rx_mem [DEPTH];
  logic [ADDR_W-1:0] rx_wptr_q, rx_rptr_q;
  logic [ADDR_W:0]   rx_cnt_q, rx_cnt_d;
  logic              rx_push, rx_pop, rx_drop;
  logic              rx_ovf_q, rx_en_q;

  // ---------------- TX side ----------------
  assign host.tx_ready = (tx_cnt_q != FULL);
  assign tx_push       = host.tx_valid & host.tx_ready & ~flush_i;
  assign tx_pop        = launch;

  // TX FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // TX FSM next state: a BUSY frame always runs to t_done_i, even across flush or disable
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch)   state_d = BUSY;
      BUSY:    if (t_done_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // TX FSM output: launch the head byte when idle, enabled and the FIFO holds data
  always_comb begin
    launch = 1'b0;
    if (state_q == IDLE && tx_cnt_q != '0 && tx_enable_i && !flush_i) launch = 1'b1;
  end

  // Transmitter drive: one-cycle launch pulse, byte held until the next launch
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      t_in_q  <= 8'h00;
      tx_en_q <= 1'b0;
    end else begin
      tx_en_q <= launch;
      if (launch) t_in_q <= tx_mem[tx_rptr_q];
    end
  end

  // TX occupancy next state
  always_comb begin
    tx_cnt_d = tx_cnt_q;
    if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + CNT1;
    else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - CNT1;
  end

  // TX pointers and count; flush empties the FIFO
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + PTR1;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + PTR1;
      tx_cnt_q <= tx_cnt_d;
    end
  end

  // TX storage write
  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wptr_q] <= host.tx_data;
  end

  // ---------------- RX side ----------------
  assign host.rx_valid = (rx_cnt_q != '0);
  assign host.rx_data  = host.rx_valid ? rx_mem[rx_rptr_q] : 8'h00;
  assign rx_pop        = host.rx_valid & host.rx_ready & ~flush_i;
  // A full FIFO still accepts when the host frees a slot in the same cycle
  assign rx_push       = r_done_i & ((rx_cnt_q != FULL) | rx_pop) & ~flush_i;
  assign rx_drop       = r_done_i & (rx_cnt_q == FULL) & ~rx_pop & ~flush_i;

  // RX occupancy next state
  always_comb begin
    rx_cnt_d = rx_cnt_q;
    if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + CNT1;
    else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - CNT1;
  end

  // RX pointers, count and sticky overflow; flush empties and clears overflow
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
      rx_ovf_q  <= 1'b0;
    end else begin
      if (rx_push) rx_wptr_q <= rx_wptr_q + PTR1;
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + PTR1;
      rx_cnt_q <= rx_cnt_d;
      if (rx_drop) rx_ovf_q <= 1'b1;
    end
  end

  // RX storage write
  always_ff @(posedge clk_i) begin
    if (rx_push) rx_mem[rx_wptr_q] <= r_data_i;
  end

  // Receiver enable registered by one cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) rx_en_q <= 1'b0;
    else       rx_en_q <= rx_enable_i;
  end

  assign tx_count_o    = tx_cnt_q;
  assign rx_count_o    = rx_cnt_q;
  assign rx_overflow_o = rx_ovf_q;
  assign t_in_o        = t_in_q;
  assign tx_en_o       = tx_en_q;
  assign rx_en_o       = rx_en_q;
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Scoreboard bench for uart_fifo_bridge: TX bytes are queued when accepted and checked
// at each launch; RX bytes are queued on receive and checked when the host pops them.
module tb_uart_fifo_bridge;
  logic       clk = 1'b0;
  logic       rst;
  logic       tx_enable, rx_enable, flush;
  logic [4:0] tx_count, rx_count;
  logic       rx_overflow;
  logic [7:0] t_in;
  logic       tx_en;
  logic       t_done;
  logic       rx_en;
  logic [7:0] r_data;
  logic       r_done;

  uart_fifo_bridge_if bus();

  uart_fifo_bridge #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .host(bus.slave),
    .tx_enable_i(tx_enable), .rx_enable_i(rx_enable), .flush_i(flush),
    .tx_count_o(tx_count), .rx_count_o(rx_count), .rx_overflow_o(rx_overflow),
    .t_in_o(t_in), .tx_en_o(tx_en), .t_done_i(t_done),
    .rx_en_o(rx_en), .r_data_i(r_data), .r_done_i(r_done)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  int         launches = 0;
  bit         frame_busy = 0;
  logic [7:0] last_tin = 8'h00;
  bit         auto_done = 1;
  bit         done_req = 0;
  int         done_cnt = -1;

  // Launch monitor: order, one launch per frame, byte stable during the frame
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_busy) begin
        checks++;
        if (tx_en) begin
          errors++;
          $display("FAIL launch_during_frame tx_en_o=%0b required 0", tx_en);
        end
        checks++;
        if (t_in !== last_tin) begin
          errors++;
          $display("FAIL t_in_stable got %02h required %02h", t_in, last_tin);
        end
        if (t_done) frame_busy = 0;
      end else if (tx_en) begin
        checks++;
        launches++;
        if (tx_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_launch t_in_o=%02h required no launch", t_in);
        end else begin
          last_tin = tx_q.pop_front();
          if (t_in !== last_tin) begin
            errors++;
            $display("FAIL launch_byte got %02h required %02h", t_in, last_tin);
          end
        end
        frame_busy = 1;
      end
    end
  end

  // Transmitter model: frame completes 3 cycles after the launch pulse, or on request
  initial begin
    t_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      t_done = 1'b0;
      if (tx_en && auto_done) done_cnt = 3;
      else if (done_cnt > 0) done_cnt--;
      if (done_cnt == 0 || done_req) begin
        t_done = 1'b1;
        done_cnt = -1;
        done_req = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_tx(input logic [7:0] d);
    bus.tx_valid = 1'b1;
    bus.tx_data  = d;
    if (tx_count != 5'd16) tx_q.push_back(d);
    tick(1);
    bus.tx_valid = 1'b0;
  endtask

  task automatic recv(input logic [7:0] d);
    r_done = 1'b1;
    r_data = d;
    if (rx_q.size() < 16) rx_q.push_back(d);
    tick(1);
    r_done = 1'b0;
  endtask

  task automatic pop_rx(input int n);
    logic [7:0] e;
    bus.rx_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (rx_q.size() == 0) begin
        errors++;
        $display("FAIL rx_pop_model_empty i=%0d", i);
      end else begin
        e = rx_q.pop_front();
        if (bus.rx_valid !== 1'b1 || bus.rx_data !== e) begin
          errors++;
          $display("FAIL rx_pop got v=%0b d=%02h required v=1 d=%02h", bus.rx_valid, bus.rx_data, e);
        end
      end
      tick(1);
    end
    bus.rx_ready = 1'b0;
  endtask

  task automatic wait_tx_drain();
    int n = 0;
    while ((tx_q.size() != 0 || frame_busy || tx_count != 0) && n < 2000) begin
      tick(1);
      n++;
    end
    tick(2);
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL tx_drain_timeout pending=%0d count=%0d required 0", tx_q.size(), tx_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    checks++;
    if (tx_count !== 0 || rx_count !== 0 || bus.tx_ready !== 1'b1 || bus.rx_valid !== 1'b0 ||
        bus.rx_data !== 8'h00 || t_in !== 8'h00 || tx_en !== 1'b0 || rx_en !== 1'b0 ||
        rx_overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state txc=%0d rxc=%0d rdy=%0b rv=%0b rd=%02h tin=%02h ten=%0b ren=%0b ovf=%0b required 0 0 1 0 00 00 0 0 0",
               tx_count, rx_count, bus.tx_ready, bus.rx_valid, bus.rx_data, t_in, tx_en, rx_en, rx_overflow);
    end
    rx_enable = 1'b1;
    checks++;
    if (rx_en !== 1'b0) begin errors++; $display("FAIL rx_en_delay got %0b required 0", rx_en); end
    tick(1);
    checks++;
    if (rx_en !== 1'b1) begin errors++; $display("FAIL rx_en_follow got %0b required 1", rx_en); end
  endtask

  task automatic test_single();
    int l0 = launches;
    push_tx(8'hA5);
    checks++;
    if (tx_count !== 5'd1 || tx_en !== 1'b0) begin
      errors++;
      $display("FAIL single_after_push count=%0d tx_en=%0b required 1 0", tx_count, tx_en);
    end
    tick(1);
    checks++;
    if (tx_en !== 1'b1 || t_in !== 8'hA5 || tx_count !== 5'd0) begin
      errors++;
      $display("FAIL single_launch tx_en=%0b t_in=%02h count=%0d required 1 a5 0", tx_en, t_in, tx_count);
    end
    wait_tx_drain();
    checks++;
    if (launches - l0 != 1) begin errors++; $display("FAIL single_launch_count got %0d required 1", launches - l0); end
  endtask

  task automatic test_back_to_back();
    push_tx(8'h31);
    push_tx(8'h32);
    checks++;
    if (tx_count !== 5'd1) begin errors++; $display("FAIL push_pop_same_cycle count=%0d required 1", tx_count); end
    push_tx(8'h33);
    push_tx(8'h34);
    wait_tx_drain();
  endtask

  task automatic test_full();
    int l0;
    tx_enable = 1'b0;
    for (int i = 1; i <= 16; i++) push_tx(8'(i));
    checks++;
    if (tx_count !== 5'd16 || bus.tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL tx_full count=%0d ready=%0b required 16 0", tx_count, bus.tx_ready);
    end
    push_tx(8'h11);
    checks++;
    if (tx_count !== 5'd16) begin errors++; $display("FAIL tx_push_when_full count=%0d required 16", tx_count); end
    l0 = launches;
    tx_enable = 1'b1;
    wait_tx_drain();
    checks++;
    if (launches - l0 != 16) begin errors++; $display("FAIL tx_full_launches got %0d required 16", launches - l0); end
  endtask

  task automatic test_enable();
    int l0 = launches;
    tx_enable = 1'b0;
    push_tx(8'h21);
    push_tx(8'h22);
    push_tx(8'h23);
    tick(10);
    checks++;
    if (launches != l0 || tx_count !== 5'd3) begin
      errors++;
      $display("FAIL tx_disabled launches=%0d count=%0d required %0d 3", launches, tx_count, l0);
    end
    tx_enable = 1'b1;
    wait_tx_drain();
    checks++;
    if (launches - l0 != 3) begin errors++; $display("FAIL tx_resume_launches got %0d required 3", launches - l0); end
  endtask

  task automatic test_rx_overflow();
    bus.rx_ready = 1'b0;
    for (int i = 1; i <= 17; i++) recv(8'h40 + 8'(i));
    checks++;
    if (rx_count !== 5'd16 || rx_overflow !== 1'b1) begin
      errors++;
      $display("FAIL rx_overflow count=%0d ovf=%0b required 16 1", rx_count, rx_overflow);
    end
    pop_rx(16);
    checks++;
    if (rx_count !== 5'd0 || bus.rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL rx_empty_after_pop count=%0d valid=%0b required 0 0", rx_count, bus.rx_valid);
    end
  endtask

  task automatic test_rx_full_pop();
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    checks++;
    if (rx_overflow !== 1'b0) begin errors++; $display("FAIL flush_clears_ovf got %0b required 0", rx_overflow); end
    for (int i = 0; i < 16; i++) recv(8'h60 + 8'(i));
    // Receive and pop in the same cycle while full
    checks++;
    if (bus.rx_data !== rx_q[0]) begin
      errors++;
      $display("FAIL rx_full_head got %02h required %02h", bus.rx_data, rx_q[0]);
    end
    void'(rx_q.pop_front());
    rx_q.push_back(8'h70);
    bus.rx_ready = 1'b1;
    r_done = 1'b1;
    r_data = 8'h70;
    tick(1);
    r_done = 1'b0;
    bus.rx_ready = 1'b0;
    checks++;
    if (rx_count !== 5'd16 || rx_overflow !== 1'b0) begin
      errors++;
      $display("FAIL rx_full_push_pop count=%0d ovf=%0b required 16 0", rx_count, rx_overflow);
    end
    pop_rx(16);
  endtask

  task automatic test_flush_busy();
    int l0;
    int n = 0;
    auto_done = 0;
    tx_enable = 1'b0;
    for (int i = 0; i < 6; i++) push_tx(8'h81 + 8'(i));
    recv(8'h55);
    recv(8'h56);
    tx_enable = 1'b1;
    while (!frame_busy && n < 20) begin tick(1); n++; end
    checks++;
    if (!frame_busy) begin errors++; $display("FAIL flush_no_launch busy=%0b required 1", frame_busy); end
    tick(1);
    checks++;
    if (tx_count !== 5'd5) begin errors++; $display("FAIL flush_pre_count got %0d required 5", tx_count); end
    l0 = launches;
    flush = 1'b1;
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h99;
    r_done = 1'b1;
    r_data = 8'h77;
    tick(1);
    flush = 1'b0;
    bus.tx_valid = 1'b0;
    r_done = 1'b0;
    tx_q.delete();
    rx_q.delete();
    checks++;
    if (tx_count !== 0 || rx_count !== 0 || rx_overflow !== 1'b0 || bus.rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_state txc=%0d rxc=%0d ovf=%0b rv=%0b required 0 0 0 0", tx_count, rx_count, rx_overflow, bus.rx_valid);
    end
    tick(3);
    done_req = 1;
    tick(10);
    checks++;
    if (launches != l0 || frame_busy || tx_count !== 0) begin
      errors++;
      $display("FAIL flush_after_done launches=%0d busy=%0b count=%0d required %0d 0 0", launches, frame_busy, tx_count, l0);
    end
    auto_done = 1;
  endtask

  initial begin
    rst = 1'b1;
    tx_enable = 1'b1;
    rx_enable = 1'b0;
    flush = 1'b0;
    r_data = 8'h00;
    r_done = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    bus.rx_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_enable();
    test_rx_overflow();
    test_rx_full_pop();
    test_flush_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
